// File: rtl/serpar_seq_ctrl.sv
// Sequencer for the byte-serial/parallel I/O buffer of the masked SKINNY-128-384+ core.
// Optional tweakey write-back state is enabled by defining SERPAR_TK_CAPTURE_EN.
module serpar_seq_ctrl #(
  parameter int unsigned BUF_BYTES = 112,
  parameter int unsigned OUT_BYTES = 32,
  parameter int unsigned CNT_W     = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din_valid,
  output logic din_ready,
  output logic dout_valid,
  input  logic dout_ready,
  output logic core_start,
  input  logic core_done,
  output logic wr,
  output logic rd,
  output logic en,
  output logic ken,
  output logic busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] GO   = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] CAPT = 3'd4;
`ifdef SERPAR_TK_CAPTURE_EN
  localparam logic [2:0] CAPK = 3'd5;
`endif
  localparam logic [2:0] READ = 3'd6;

  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(BUF_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(OUT_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_phase;

  assign in_phase = (state_q == IDLE) || (state_q == LOAD);

  // Handshakes and strobes are suppressed in a clr cycle so nothing is half-accepted;
  // din_ready also drops while reset is held so every output is 0 in reset.
  assign din_ready  = rst_n & ~clr & in_phase;
  assign dout_valid = ~clr & (state_q == READ);
  assign wr         = din_valid & din_ready;
  assign rd         = dout_valid & dout_ready;
  assign core_start = ~clr & (state_q == GO);
  assign en         = ~clr & (state_q == CAPT);
`ifdef SERPAR_TK_CAPTURE_EN
  assign ken        = ~clr & (state_q == CAPK);
`else
  assign ken        = 1'b0;
`endif
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, LOAD: begin
        // cnt is 0 in IDLE, so the first accept shares the LOAD counting path
        if (wr) begin
          if (cnt_q == LAST_IN) begin
            state_d = GO;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
      end
      GO: state_d = RUN;
      RUN: begin
        if (core_done) state_d = CAPT;
      end
`ifdef SERPAR_TK_CAPTURE_EN
      CAPT: state_d = CAPK;
      CAPK: state_d = READ;
`else
      CAPT: state_d = READ;
`endif
      READ: begin
        if (rd) begin
          if (cnt_q == LAST_OUT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serpar_seq_ctrl.sv
// Scoreboard bench for serpar_seq_ctrl: stimulus queues expected strobe events,
// a negedge monitor pops and compares them. Define SERPAR_TK_CAPTURE_EN to match the DUT build.
module tb_serpar_seq_ctrl;
  localparam int BUF_BYTES = 112;
  localparam int OUT_BYTES = 32;

  logic clk = 1'b0;
  logic rst_n, clr, din_valid, din_ready, dout_valid, dout_ready;
  logic core_start, core_done, wr, rd, en, ken, busy;

  int  checks = 0;
  int  errors = 0;
  byte exp_q[$];

  always #5 clk = ~clk;

  serpar_seq_ctrl #(
    .BUF_BYTES(BUF_BYTES),
    .OUT_BYTES(OUT_BYTES),
    .CNT_W    (7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .core_start(core_start),
    .core_done (core_done),
    .wr        (wr),
    .rd        (rd),
    .en        (en),
    .ken       (ken),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe cycle must match the next queued event
  always @(negedge clk) begin
    if (rst_n) begin
      int  n;
      byte code;
      n = int'(wr) + int'(rd) + int'(en) + int'(ken);
      check("strobe_onehot", (n <= 1), 1);
      check("ready_valid_excl", (din_ready & dout_valid), 0);
      code = 0;
      if (wr) code = "W";
      else if (rd) code = "R";
      else if (en) code = "E";
      else if (ken) code = "K";
      else if (core_start) code = "S";
      if (code != 0) begin
        if (exp_q.size() == 0) check("unexpected_event", code, 0);
        else check("event_seq", code, exp_q.pop_front());
      end
    end
  end

  task automatic send_bytes(input int n, input bit toggle, input bit poke_done);
    int sent = 0;
    int cyc  = 0;
    while (sent < n) begin
      core_done = poke_done && (sent == 20);
      if (toggle && cyc[0]) din_valid = 1'b0;
      else begin
        din_valid = 1'b1;
        exp_q.push_back("W");
        sent++;
        if (sent == n) exp_q.push_back("S");
      end
      cyc++;
      step();
    end
    din_valid = 1'b0;
    core_done = 1'b0;
    check("start_latency", core_start, 1);
  endtask

  task automatic run_core(input int cycles, input bit spurious_din);
    step();  // GO -> RUN
    for (int i = 0; i < cycles; i++) begin
      din_valid = spurious_din && (i < 5);
      step();
    end
    din_valid = 1'b0;
    core_done = 1'b1;
    exp_q.push_back("E");
    step();
    core_done = 1'b0;
    check("en_latency", en, 1);
`ifdef SERPAR_TK_CAPTURE_EN
    exp_q.push_back("K");
    step();
    check("ken_after_en", ken, 1);
    check("no_dout_in_capk", dout_valid, 0);
    step();
    check("dout_after_ken", dout_valid, 1);
`else
    step();
    check("ken_tied_low", ken, 0);
    check("dout_after_en", dout_valid, 1);
`endif
  endtask

  task automatic read_bytes(input int n, input int stall_at);
    int got   = 0;
    int stall = 5;
    while (got < n) begin
      core_done = (got == 10);
      if (got == stall_at && stall > 0) begin
        dout_ready = 1'b0;
        #1;
        check("stall_valid_held", dout_valid, 1);
        check("stall_no_rd", rd, 0);
        stall--;
      end else begin
        dout_ready = 1'b1;
        exp_q.push_back("R");
        got++;
      end
      step();
    end
    dout_ready = 1'b0;
    core_done  = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_din_ready", din_ready, 1);
  endtask

  task automatic full_flow();
    send_bytes(BUF_BYTES, 1'b0, 1'b0);
    run_core(40, 1'b0);
    read_bytes(OUT_BYTES, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; din_valid = 1'b0; dout_ready = 1'b0; core_done = 1'b0;
    step();
    check("rst_busy", busy, 0);
    check("rst_din_ready", din_ready, 0);
    check("rst_strobes", {wr, rd, en, ken, core_start, dout_valid}, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 0);
    check("post_rst_din_ready", din_ready, 1);

    full_flow();

    // Backpressure plus spurious core_done/din_valid
    send_bytes(BUF_BYTES, 1'b1, 1'b1);
    run_core(40, 1'b1);
    read_bytes(OUT_BYTES, 7);

    // Abort in RUN; the late core_done must not produce en
    send_bytes(BUF_BYTES, 1'b0, 1'b0);
    step();
    check("in_run_busy", busy, 1);
    clr = 1'b1;
    #1;
    check("clr_no_strobes", {wr, rd, en, ken, core_start}, 0);
    step();
    clr = 1'b0;
    check("clr_idle", busy, 0);
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("late_done_ignored", busy, 0);
    full_flow();

    // Asynchronous reset mid-LOAD with cnt=50
    for (int i = 0; i < 50; i++) begin
      din_valid = 1'b1;
      exp_q.push_back("W");
      step();
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_outs", {din_ready, wr, rd, en, ken, core_start, dout_valid}, 0);
    din_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rel_busy", busy, 0);
    check("rel_din_ready", din_ready, 1);
    full_flow();

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serpar_seq_ctrl.md
Name: serpar_seq_ctrl

Overview:
- Sequencer for the byte-serial/parallel I/O buffer of the masked SKINNY-128-384+ core.
- Accepts BUF_BYTES input bytes by valid/ready handshake, asserting the buffer write strobe on each accepted byte.
- Then starts the cipher core, waits for completion and pulses the buffer capture strobe.
- Finally streams OUT_BYTES result bytes out MSB-first via valid/ready, driving the buffer read-shift strobe.

Parameters:
- BUF_BYTES, 112, bytes shifted in per invocation (full 896-bit buffer).
- OUT_BYTES, 32, bytes streamed out per invocation (two 128-bit state shares).
- CNT_W, 7, counter width; must satisfy 2**CNT_W > BUF_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous soft abort to IDLE.
- din_valid  in  1  input byte valid (byte itself goes straight to buffer data_in).
- din_ready  out  1  controller accepts input byte.
- dout_valid  out  1  buffer top byte is a valid result byte.
- dout_ready  in  1  consumer takes result byte.
- core_start  out  1  one-cycle start pulse to cipher core.
- core_done  in  1  one-cycle completion pulse from cipher core.
- wr  out  1  buffer shift-in strobe.
- rd  out  1  buffer shift-out strobe.
- en  out  1  buffer state-capture strobe (upper 256 bits from core).
- ken  out  1  buffer tweakey-capture strobe (lower 640 bits from core).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, cnt 0. Reset mid-operation aborts immediately. Buffer contents are not cleared; the buffer has no reset.
- States: IDLE, LOAD, GO, RUN, CAPT, CAPK (optional), READ.
- IDLE:
  - din_ready=1; wr = din_valid & din_ready (combinational).
  - On accept: cnt<=1, go to LOAD.
- LOAD:
  - din_ready=1; cnt increments per accepted byte.
  - When the accepted byte is number BUF_BYTES (cnt==BUF_BYTES-1 at accept): go to GO, cnt<=0.
  - Gaps in din_valid stall with no wr.
- GO: core_start=1 for exactly one cycle, then RUN.
- RUN:
  - Wait for core_done; core_done is sampled only in RUN and ignored in all other states.
  - On core_done go to CAPT.
- CAPT: en=1 for exactly one cycle, then CAPK if the optional feature is enabled, otherwise READ.
- READ:
  - dout_valid=1; rd = dout_valid & dout_ready (combinational).
  - cnt counts accepted bytes. After byte OUT_BYTES: go to IDLE, cnt<=0.
  - dout_ready low stalls indefinitely with the byte stable.
- Strobe exclusivity: at most one of wr, rd, en, ken is high in any cycle. Buffer priority is therefore irrelevant but consistent.
- din_ready and dout_valid are never high together. din_valid outside IDLE/LOAD is ignored.
- clr:
  - Synchronous; wins over all other events that cycle: all strobes 0, next state IDLE, cnt 0.
  - clr in RUN does not stop the core; a later core_done is ignored.
- Latency:
  - Last input accept to core_start: 1 cycle.
  - core_done to en: 1 cycle.
  - en to first dout_valid: 1 cycle, or 2 with the optional feature.
- Back-to-back: a new input byte is accepted the cycle after the last output accept (IDLE).

Optional Feature:
- Macro SERPAR_TK_CAPTURE_EN.
- Defined:
  - After CAPT, state CAPK asserts ken for one cycle, loading the updated tweakey shares into the buffer's lower 640 bits, then READ.
  - The tweakey is not streamed out. Readout shifts the buffer, so the captured tweakey moves toward the top; the host must reload all BUF_BYTES next invocation.
- Undefined: no CAPK state; ken tied 0.

Test Plan:
- Reset: rst_n low mid-LOAD (cnt=50) -> asynchronous return to IDLE; all outputs 0 while low; busy=0, din_ready=1 after release.
- Full flow:
  - 112 bytes with din_valid constant -> exactly 112 wr pulses, then core_start one cycle later.
  - core_done after 40 cycles -> en next cycle.
  - 32 dout handshakes with dout_ready=1 -> 32 rd pulses, then IDLE.
- Backpressure: din_valid toggled 1/0 and dout_ready low for 5 cycles -> wr only on valid cycles, 112 total; dout_valid held, no rd while stalled.
- Abort: clr in RUN, then core_done -> no en; state IDLE; next load starts cleanly at cnt 0.
- Spurious inputs: core_done in LOAD/READ and din_valid in RUN -> no effect; the one-hot strobe check holds every cycle.
- Feature: with SERPAR_TK_CAPTURE_EN -> ken one cycle after en, dout_valid one cycle later; without it -> ken never asserted.
